// File: rtl/crc3_sched.sv
// Two-port CRC-3 job scheduler: arbitrates generate/check requests round-robin
// onto one shared serial CRC-3 engine and returns codewords or syndromes.
module crc3_sched (
    input  logic       clk,
    input  logic       rst,
    input  logic       gen_req,
    input  logic [5:0] gen_msg,
    output logic       gen_done,
    output logic [8:0] gen_code,
    input  logic       chk_req,
    input  logic [8:0] chk_word,
    output logic       chk_done,
    output logic [2:0] chk_syn,
    output logic       chk_ok,
    output logic       eng_rst,
    output logic       eng_flag,
    output logic [8:0] eng_data,
    input  logic [2:0] eng_crc
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, RESP} state_t;

    localparam logic [3:0] RUN_LAST = 4'd8;

    state_t     state, state_nxt;
    logic [3:0] cnt;
    logic       last_chk;   // 1 = check port was served last
    logic       job_chk;    // port owning the job in flight
    logic       any_req;
    logic       grant_chk;

    assign any_req   = gen_req | chk_req;
    // On a tie the port not served last wins; a lone requester always wins.
    assign grant_chk = chk_req & (~gen_req | ~last_chk);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = LOAD;
            LOAD:    state_nxt = RUN;
            RUN:     if (cnt == RUN_LAST) state_nxt = CAPT;
            CAPT:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= 4'd0;
            last_chk <= 1'b1;
            job_chk  <= 1'b0;
            eng_rst  <= 1'b0;
            eng_flag <= 1'b0;
            eng_data <= 9'd0;
            gen_done <= 1'b0;
            chk_done <= 1'b0;
            gen_code <= 9'd0;
            chk_syn  <= 3'd0;
            chk_ok   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        job_chk  <= grant_chk;
                        eng_rst  <= 1'b1;
                        eng_flag <= grant_chk;
                        eng_data <= grant_chk ? chk_word : {gen_msg, 3'b000};
                    end
                    cnt <= 4'd0;
                end
                LOAD: begin
                    eng_rst <= 1'b0;
                    cnt     <= 4'd0;
                end
                RUN: begin
                    cnt <= (cnt == RUN_LAST) ? 4'd0 : cnt + 4'd1;
                end
                CAPT: begin
                    // Engine remainder has seen all 9 shifts by this edge.
                    if (job_chk) begin
                        chk_syn  <= eng_crc;
                        chk_ok   <= (eng_crc == 3'b000);
                        chk_done <= 1'b1;
                    end else begin
                        gen_code <= {eng_data[8:3], eng_crc};
                        gen_done <= 1'b1;
                    end
                end
                RESP: begin
                    gen_done <= 1'b0;
                    chk_done <= 1'b0;
                    last_chk <= job_chk;
                end
                default: begin
                    eng_rst <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_crc3_sched.sv
// Scoreboard bench for crc3_sched with a behavioural serial CRC-3 engine.
module tb_crc3_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       gen_req, chk_req;
    logic [5:0] gen_msg;
    logic [8:0] chk_word;
    logic       gen_done, chk_done, chk_ok;
    logic [8:0] gen_code;
    logic [2:0] chk_syn;
    logic       eng_rst, eng_flag;
    logic [8:0] eng_data;
    logic [2:0] eng_crc;

    crc3_sched dut (
        .clk(clk), .rst(rst),
        .gen_req(gen_req), .gen_msg(gen_msg), .gen_done(gen_done), .gen_code(gen_code),
        .chk_req(chk_req), .chk_word(chk_word), .chk_done(chk_done),
        .chk_syn(chk_syn), .chk_ok(chk_ok),
        .eng_rst(eng_rst), .eng_flag(eng_flag), .eng_data(eng_data), .eng_crc(eng_crc)
    );

    always #5 clk = ~clk;

    // Shared serial engine: load on eng_rst, else shift MSB first.
    logic [8:0] sh;
    logic [2:0] c;
    always @(posedge clk) begin
        if (eng_rst) begin
            sh <= eng_data;
            c  <= 3'b000;
        end else begin
            c  <= {c[2] ^ c[1], c[0], c[2] ^ sh[8]};
            sh <= {sh[7:0], 1'b0};
        end
    end
    assign eng_crc = c;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       is_chk;
        logic [8:0] data;
        logic [8:0] res;
        logic       ok;
        int         exp_cyc;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops the scoreboard on every done pulse.
    logic [8:0] hold_code;
    logic [2:0] hold_syn;
    logic       hold_ok;
    logic       prev_er;
    initial begin
        exp_t e;
        hold_code = '0; hold_syn = '0; hold_ok = 1'b0; prev_er = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_code = '0; hold_syn = '0; hold_ok = 1'b0; prev_er = 1'b0;
            end else begin
                if (gen_done && chk_done) check("both_done", 1, 0);
                if (eng_rst) begin
                    check("eng_rst_width", {31'd0, prev_er}, 0);
                    if (q.size() > 0) begin
                        check("load_flag", {31'd0, eng_flag}, {31'd0, q[0].is_chk});
                        check("load_data", {23'd0, eng_data}, {23'd0, q[0].data});
                    end
                end
                if (gen_done || chk_done) begin
                    if (q.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = q.pop_front();
                        check("done_port", {31'd0, chk_done}, {31'd0, e.is_chk});
                        if (e.exp_cyc >= 0) check("latency", cyc, e.exp_cyc);
                        if (e.is_chk) begin
                            check("chk_syn", {29'd0, chk_syn}, {23'd0, e.res});
                            check("chk_ok", {31'd0, chk_ok}, {31'd0, e.ok});
                            check("gen_code_held", {23'd0, gen_code}, {23'd0, hold_code});
                            hold_syn = e.res[2:0];
                            hold_ok  = e.ok;
                        end else begin
                            check("gen_code", {23'd0, gen_code}, {23'd0, e.res});
                            check("chk_syn_held", {29'd0, chk_syn}, {29'd0, hold_syn});
                            check("chk_ok_held", {31'd0, chk_ok}, {31'd0, hold_ok});
                            hold_code = e.res;
                        end
                    end
                end
                prev_er = eng_rst;
            end
        end
    end

    task automatic check_zero(input string tag);
        check({tag, "_gen_done"}, {31'd0, gen_done}, 0);
        check({tag, "_chk_done"}, {31'd0, chk_done}, 0);
        check({tag, "_gen_code"}, {23'd0, gen_code}, 0);
        check({tag, "_chk_syn"},  {29'd0, chk_syn}, 0);
        check({tag, "_chk_ok"},   {31'd0, chk_ok}, 0);
        check({tag, "_eng_rst"},  {31'd0, eng_rst}, 0);
        check({tag, "_eng_flag"}, {31'd0, eng_flag}, 0);
        check({tag, "_eng_data"}, {23'd0, eng_data}, 0);
    endtask

    task automatic push(input logic is_chk, input logic [8:0] data, input logic [8:0] res,
                        input int exp_cyc);
        exp_t e;
        e.is_chk = is_chk; e.data = data; e.res = res;
        e.ok = (res == 9'd0); e.exp_cyc = exp_cyc;
        q.push_back(e);
    endtask

    // Issue one job from idle, wait for its done (bounded), then drop the request.
    task automatic run_job(input logic is_chk, input logic [8:0] val, input logic [8:0] res);
        bit seen = 0;
        if (is_chk) begin
            chk_word = val; chk_req = 1'b1;
            push(1'b1, val, res, cyc + 12);
        end else begin
            gen_msg = val[5:0]; gen_req = 1'b1;
            push(1'b0, {val[5:0], 3'b000}, res, cyc + 12);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_chk ? chk_done : gen_done) begin seen = 1; break; end
        end
        if (!seen) check("job_timeout", 0, 1);
        gen_req = 1'b0; chk_req = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n;
        int dones;
        rst = 1'b1; gen_req = 1'b0; chk_req = 1'b0; gen_msg = '0; chk_word = '0;
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        run_job(1'b0, 9'b000100000, 9'b100000010);
        run_job(1'b1, 9'b100000010, 9'b000000000);
        run_job(1'b1, 9'b100000011, 9'b000000001);
        run_job(1'b0, 9'b000000000, 9'b000000000);
        run_job(1'b0, 9'b000000001, 9'b000001101);
        run_job(1'b1, 9'b000001101, 9'b000000000);
        run_job(1'b1, 9'b000001100, 9'b000000001);

        // Abort a gen job at RUN counter 4; the still-high request is re-served.
        gen_msg = 6'b100000; gen_req = 1'b1;
        n = cyc;
        while (cyc < n + 6) @(negedge clk);
        check("abort_eng_rst", {31'd0, eng_rst}, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_zero("abort");
        push(1'b0, 9'b100000000, 9'b100000010, cyc + 12);
        dones = 0;
        for (int i = 0; i < 40 && dones == 0; i++) begin
            @(negedge clk);
            if (gen_done) dones++;
        end
        if (dones == 0) check("abort_timeout", 0, 1);
        gen_req = 1'b0;
        repeat (2) @(negedge clk);

        // Both ports requesting continuously: gen first, then alternate.
        rst = 1'b1;
        gen_msg = 6'b100000; chk_word = 9'b100000011;
        gen_req = 1'b1; chk_req = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        push(1'b0, 9'b100000000, 9'b100000010, cyc + 12);
        push(1'b1, 9'b100000011, 9'b000000001, -1);
        push(1'b0, 9'b100000000, 9'b100000010, -1);
        push(1'b1, 9'b100000011, 9'b000000001, -1);
        dones = 0;
        for (int i = 0; i < 80 && dones < 4; i++) begin
            @(negedge clk);
            if (gen_done || chk_done) dones++;
        end
        check("rr_done_count", dones, 4);
        gen_req = 1'b0; chk_req = 1'b0;
        repeat (20) @(negedge clk);
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/crc3_sched.md
CRC3_SCHED -- requirements
Module: crc3_sched

Interface
REQ-001 clk  input  1  rising-edge system clock.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 gen_req  input  1  generate-request level; holds gen_msg stable until gen_done.
REQ-004 gen_msg  input  6  message to encode.
REQ-005 gen_done  output  1  one-cycle pulse; gen_code valid.
REQ-006 gen_code  output  9  codeword {gen_msg, crc[2:0]}; held until next gen result.
REQ-007 chk_req  input  1  check-request level; holds chk_word stable until chk_done.
REQ-008 chk_word  input  9  received codeword to check.
REQ-009 chk_done  output  1  one-cycle pulse; chk_syn/chk_ok valid.
REQ-010 chk_syn  output  3  syndrome; held until next check result.
REQ-011 chk_ok  output  1  1 when chk_syn == 3'b000; held with chk_syn.
REQ-012 eng_rst  output  1  load strobe to shared serial CRC-3 engine.
REQ-013 eng_flag  output  1  engine mode: 0 = generate (low 3 data bits forced 0), 1 = check (all 9 bits).
REQ-014 eng_data  output  9  engine data word, shifted MSB first by the engine.
REQ-015 eng_crc  input  3  engine remainder, valid after 9 shift cycles.

Function
REQ-016 Engine contract: loads on an edge with eng_rst=1, shifts one bit per edge with eng_rst=0; remainder per step {c2^c1, c0, c2^d}, from 000 (g = x^3+x^2+1).
REQ-017 States IDLE, LOAD, RUN, CAPT, RESP; only one job in flight.
REQ-018 IDLE: any req high at an edge -> grant per REQ-019, go LOAD; no req -> stay IDLE.
REQ-019 Round-robin: single requester wins; both high -> winner is the port not served last; last-served pointer resets to "chk", so gen wins first tie.
REQ-020 LOAD (1 cycle): eng_rst=1; gen job: eng_flag=0, eng_data={gen_msg,3'b000}; chk job: eng_flag=1, eng_data=chk_word.
REQ-021 RUN (9 cycles, 4-bit counter 0..8): eng_rst=0, eng_flag/eng_data held; counter==8 -> CAPT.
REQ-022 CAPT (1 cycle): eng_crc sampled at exit edge into gen_code[2:0] (with gen_msg in [8:3]) or chk_syn/chk_ok of granted port only; -> RESP.
REQ-023 RESP (1 cycle): granted port's done=1; update last-served pointer; -> IDLE.
REQ-024 Latency: accept edge k -> done high during cycle after edge k+11; back-to-back jobs every 12 cycles min.
REQ-025 Req still high in first IDLE cycle after done counts as new request.
REQ-026 Req dropped mid-job: job completes, done still pulses; outputs of non-granted port untouched.
REQ-027 eng_rst=0 in all states except LOAD; gen_done and chk_done never simultaneous.

Reset
REQ-028 rst high at an edge: state->IDLE, counter->0, eng_rst/eng_flag/eng_data->0, gen_done/chk_done->0, gen_code->0, chk_syn->0, chk_ok->0, pointer->"chk".
REQ-029 rst mid-job aborts: no done pulse, no output update; new arbitration starts first cycle after rst low.

Verification
REQ-030 gen_req=1, gen_msg=6'b100000 -> gen_done 11 cycles after accept edge, gen_code=9'b100000010.
REQ-031 chk_req=1, chk_word=9'b100000010 -> chk_done, chk_syn=000, chk_ok=1; chk_word=9'b100000011 -> chk_syn=001, chk_ok=0.
REQ-032 gen_req and chk_req both high continuously after rst -> gen served first, then chk, alternating; done pulses 12 cycles apart.
REQ-033 rst pulsed during RUN counter=4 -> no done, eng_rst=0, outputs zeroed; request re-served after rst low with full latency.
REQ-034 eng_rst high exactly 1 cycle per job and 0 for the next 9; eng_flag=0 for gen job, 1 for chk job throughout LOAD/RUN.
